fft_twiddle_gen: RTL and testbench
==================================

Name: fft_twiddle_gen

Overview:
- Parametrised twiddle-factor generator for the radix-2 DIT FFT datapath of the CWT engine.
- On start, it streams W_N^k = cos(2πk/N) − j·sin(2πk/N) for every butterfly of every stage, in order, over a valid/ready interface.
- It replaces the per-size, imaginary-only ROMs with one quarter-wave cosine table and symmetry logic.
- Supports forward and inverse (conjugate) mode.

Parameters:
LOG2N, 5, log2 of FFT size N (N=32 default); legal 3..12
DW, 16, twiddle word width, two's complement
FRAC, 8, fractional bits (Q(DW-FRAC).FRAC; +1.0 = 0x0100 at defaults)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  begin a full twiddle sequence; sampled only in IDLE
inverse  in  1  latched at start; 1 = emit conjugate twiddles (IFFT)
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last twiddle handshake
tw_valid  out  1  output word valid
tw_ready  in  1  downstream accept
tw_re  out  DW  real part
tw_im  out  DW  imaginary part
tw_k  out  LOG2N-1  twiddle index k (0..N/2-1)
tw_stage  out  ceil(log2(LOG2N))  stage number s
tw_last  out  1  marks final word of the sequence

Behaviour:
- Reset (async, rst=1): state IDLE; busy, done, tw_valid, and tw_last = 0; tw_re, tw_im, tw_k, and tw_stage = 0. Counters and the inverse latch are cleared.
- Reset mid-sequence aborts immediately. No done pulse is issued.
- Ordering: stage s = 0..LOG2N-1, butterfly b = 0..N/2-1 within each stage.
- Index: k = (b mod 2^s) << (LOG2N-1-s).
- Total words per sequence: LOG2N·N/2 (80 at defaults).
- Table: C[i] = round-to-nearest(cos(2πi/N)·2^FRAC), i = 0..N/4 (N/4+1 entries).
- Symmetry for k ≤ N/4: re = C[k], im = −C[N/4−k].
- Symmetry for N/4 < k < N/2: re = −C[N/2−k], im = −C[k−N/4].
- inverse=1 negates im after symmetry. Magnitudes are ≤ 1.0, so negation never overflows.
- Pipeline:
  - P0: index and address generation.
  - P1: synchronous dual-address ROM read, with sign and select flags delayed alongside.
  - P2: negate/mux output register.
- Latency: the first tw_valid appears 2 cycles after the start-accept cycle.
- Flow control:
  - The whole pipeline advances when (!tw_valid || tw_ready). The ROM read enable is gated by the same term.
  - Under backpressure, tw_* hold stable while tw_valid=1 and tw_ready=0.
  - With tw_ready tied high, one word is emitted per cycle.
- FSM:
  - IDLE: start=1 → RUN. Latch inverse, set busy, clear counters.
  - RUN: issue one index per advance. After issuing s=LOG2N-1, b=N/2-1 → DRAIN.
  - DRAIN: wait until the tw_last word handshakes → IDLE. Pulse done in the cycle after that handshake; clear busy in the same cycle.
- start while busy is ignored. start and the final handshake in the same cycle: start is ignored, because the FSM is not yet in IDLE.
- tw_last = 1 only on the word with s=LOG2N-1, b=N/2-1.

Decomposition:
- Package fft_tw_pkg holds:
  - N, N/2, N/4 as localparams derived from LOG2N;
  - a function computing C[i] for ROM initialisation;
  - the FSM state enum (IDLE, RUN, DRAIN);
  - the width helpers.
- Sub-module fft_qcos_rom holds the quarter-wave table: two read addresses, one shared enable, 1-cycle synchronous read, and no reset on its data path.
- Top-level fft_twiddle_gen holds the counters, the FSM, the symmetry/sign pipeline, and the handshake logic.

Test Plan:
- Defaults, inverse=0, tw_ready=1, start pulse → first tw_valid 2 cycles later. Exactly 80 words follow on consecutive cycles. tw_last is set on word 80, and done pulses 1 cycle after it.
- Stage 0 → all 16 words are k=0, re=0x0100, im=0x0000.
- Stage 4 → b=4 (k=4): re=0x00B5, im=0xFF4B. b=8 (k=8): re=0x0000, im=0xFF00. b=12 (k=12): re=0xFF4B, im=0xFF4B.
- inverse=1 → stage 4, k=8 gives im=0x0100; k=4 gives im=0x00B5; re is unchanged.
- Random tw_ready toggling → data is held stable while stalled. The sequence matches the golden model word for word, with no drops or duplicates. A start pulse asserted mid-run has no effect.
- rst asserted at word 30 → all outputs are 0 asynchronously and no done pulse is issued. A new start then restarts at s=0, b=0.

Source files
------------

// File: rtl/fft_tw_pkg.sv
// ---------------------------------------------------------------------------
// fft_tw_pkg: shared sizing helpers, FSM states and quarter-wave cosine math.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fft_tw_pkg;

  localparam int LOG2N_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic int fft_n(input int log2n);
    return 1 << log2n;
  endfunction

  function automatic int fft_half(input int log2n);
    return 1 << (log2n - 1);
  endfunction

  function automatic int fft_quarter(input int log2n);
    return 1 << (log2n - 2);
  endfunction

  function automatic int idx_w(input int log2n);
    return log2n - 1;
  endfunction

  function automatic int stage_w(input int log2n);
    return $clog2(log2n);
  endfunction

  // Entries are all in the first quadrant, so +0.5 then truncate rounds to nearest.
  function automatic int qcos_val(input int log2n, input int frac, input int i);
    real ang;
    real v;
    ang = 2.0 * 3.14159265358979323846 * real'(i) / real'(fft_n(log2n));
    v   = $cos(ang) * real'(1 << frac);
    return $rtoi(v + 0.5);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_qcos_rom.sv
// ---------------------------------------------------------------------------
// fft_qcos_rom: quarter-wave cosine table, two read ports, shared enable.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fft_qcos_rom
  import fft_tw_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEF,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int AW    = LOG2N - 1
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  output logic [DW-1:0] data0_o,
  output logic [DW-1:0] data1_o
);

  localparam int DEPTH = fft_quarter(LOG2N) + 1;

  logic [DW-1:0] tab [DEPTH];
  logic [DW-1:0] data0_q;
  logic [DW-1:0] data1_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tab
    localparam int CV = qcos_val(LOG2N, FRAC, gi);
    assign tab[gi] = DW'(CV);
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      data0_q <= tab[addr0_i];
      data1_q <= tab[addr1_i];
    end
  end

  assign data0_o = data0_q;
  assign data1_o = data1_q;

endmodule

`default_nettype wire

// File: rtl/fft_twiddle_gen.sv
// ---------------------------------------------------------------------------
// fft_twiddle_gen: streams W_N^k for every butterfly of every radix-2 stage.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fft_twiddle_gen
  import fft_tw_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEF,
  parameter int DW    = 16,
  parameter int FRAC  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      inverse_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      tw_valid_o,
  input  logic                      tw_ready_i,
  output logic [DW-1:0]             tw_re_o,
  output logic [DW-1:0]             tw_im_o,
  output logic [idx_w(LOG2N)-1:0]   tw_k_o,
  output logic [stage_w(LOG2N)-1:0] tw_stage_o,
  output logic                      tw_last_o
);

  localparam int KW = idx_w(LOG2N);
  localparam int SW = stage_w(LOG2N);
  localparam int NH = fft_half(LOG2N);
  localparam int NQ = fft_quarter(LOG2N);

  state_e        state_q;
  logic [SW-1:0] s_q;
  logic [KW-1:0] b_q;
  logic          inv_q, busy_q, done_q;

  logic          v1_q, last1_q, neg_re1_q;
  logic [KW-1:0] k1_q;
  logic [SW-1:0] s1_q;

  logic          tw_valid_q, tw_last_q;
  logic [DW-1:0] tw_re_q, tw_im_q;
  logic [KW-1:0] tw_k_q;
  logic [SW-1:0] tw_stage_q;

  logic          adv, issue, b_last, s_last, last_hs, upper_d;
  logic [KW-1:0] mask_d, k_d, addr_re_d, addr_im_d;
  logic [SW-1:0] shamt_d;
  logic [DW-1:0] rom_re, rom_im, re_d, im_d;

  assign adv     = !tw_valid_q || tw_ready_i;
  // Index 0 is issued in the accept cycle itself so the first word lands two cycles later.
  assign issue   = adv && ((state_q == ST_IDLE && start_i) || state_q == ST_RUN);
  assign b_last  = (b_q == KW'(NH - 1));
  assign s_last  = (s_q == SW'(LOG2N - 1));
  assign last_hs = tw_valid_q && tw_ready_i && tw_last_q;

  always_comb begin
    mask_d    = KW'((32'd1 << s_q) - 32'd1);
    shamt_d   = SW'(KW) - s_q;
    k_d       = (b_q & mask_d) << shamt_d;
    upper_d   = (int'(k_d) > NQ);
    addr_re_d = upper_d ? KW'(NH - int'(k_d)) : k_d;
    addr_im_d = upper_d ? KW'(int'(k_d) - NQ) : KW'(NQ - int'(k_d));
  end

  fft_qcos_rom #(
    .LOG2N (LOG2N),
    .DW    (DW),
    .FRAC  (FRAC),
    .AW    (KW)
  ) u_rom (
    .clk     (clk),
    .en_i    (adv),
    .addr0_i (addr_re_d),
    .addr1_i (addr_im_d),
    .data0_o (rom_re),
    .data1_o (rom_im)
  );

  // The imaginary part is always -C[...] before conjugation.
  assign re_d = neg_re1_q ? (-rom_re) : rom_re;
  assign im_d = inv_q ? rom_im : (-rom_im);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      b_q     <= '0;
      inv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (issue) begin
        if (b_last) begin
          b_q <= '0;
          s_q <= s_last ? '0 : s_q + 1'b1;
        end else begin
          b_q <= b_q + 1'b1;
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_RUN;
            inv_q   <= inverse_i;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (issue && b_last && s_last) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (last_hs) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q       <= 1'b0;
      last1_q    <= 1'b0;
      neg_re1_q  <= 1'b0;
      k1_q       <= '0;
      s1_q       <= '0;
      tw_valid_q <= 1'b0;
      tw_last_q  <= 1'b0;
      tw_re_q    <= '0;
      tw_im_q    <= '0;
      tw_k_q     <= '0;
      tw_stage_q <= '0;
    end else if (adv) begin
      v1_q <= issue;
      if (issue) begin
        last1_q   <= b_last && s_last;
        neg_re1_q <= upper_d;
        k1_q      <= k_d;
        s1_q      <= s_q;
      end
      tw_valid_q <= v1_q;
      tw_last_q  <= v1_q && last1_q;
      if (v1_q) begin
        tw_re_q    <= re_d;
        tw_im_q    <= im_d;
        tw_k_q     <= k1_q;
        tw_stage_q <= s1_q;
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign tw_valid_o = tw_valid_q;
  assign tw_last_o  = tw_last_q;
  assign tw_re_o    = tw_re_q;
  assign tw_im_o    = tw_im_q;
  assign tw_k_o     = tw_k_q;
  assign tw_stage_o = tw_stage_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_twiddle_gen.sv
// ---------------------------------------------------------------------------
// tb_fft_twiddle_gen: directed bench for the twiddle generator at N=32.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fft_twiddle_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic        inverse;
  logic        busy;
  logic        done;
  logic        tw_valid;
  logic        tw_ready;
  logic [15:0] tw_re;
  logic [15:0] tw_im;
  logic [3:0]  tw_k;
  logic [2:0]  tw_stage;
  logic        tw_last;

  int tests_run    = 0;
  int tests_failed = 0;

  // round(256*cos(2*pi*i/32)), i = 0..8
  int ctab [0:8] = '{256, 251, 237, 213, 181, 142, 98, 50, 0};

  fft_twiddle_gen #(.LOG2N(5), .DW(16), .FRAC(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .inverse_i  (inverse),
    .busy_o     (busy),
    .done_o     (done),
    .tw_valid_o (tw_valid),
    .tw_ready_i (tw_ready),
    .tw_re_o    (tw_re),
    .tw_im_o    (tw_im),
    .tw_k_o     (tw_k),
    .tw_stage_o (tw_stage),
    .tw_last_o  (tw_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_k(input int w);
    int s;
    int b;
    s = w / 16;
    b = w % 16;
    return (b % (1 << s)) << (4 - s);
  endfunction

  function automatic logic [15:0] m_re(input int k);
    if (k <= 8) return 16'(ctab[k]);
    return 16'(-ctab[16 - k]);
  endfunction

  function automatic logic [15:0] m_im(input int k, input bit inv);
    int v;
    if (k <= 8) v = -ctab[8 - k];
    else        v = -ctab[k - 8];
    if (inv) v = -v;
    return 16'(v);
  endfunction

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || tw_valid !== 1'b0 || tw_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: busy=%b done=%b valid=%b last=%b, required all 0", busy, done, tw_valid, tw_last);
    end
    tests_run++;
    if (tw_re !== 16'h0 || tw_im !== 16'h0 || tw_k !== 4'h0 || tw_stage !== 3'h0) begin
      tests_failed++;
      $display("FAIL reset_data: re=%h im=%h k=%0d s=%0d, required all 0", tw_re, tw_im, tw_k, tw_stage);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || tw_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: busy=%b valid=%b, required 0 0", busy, tw_valid);
    end
  endtask

  task automatic test_stream(input bit inv);
    int k;
    @(negedge clk);
    inverse  = inv;
    start    = 1'b1;
    tw_ready = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    inverse = 1'b0;
    tests_run++;
    if (tw_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL latency_cycle1: valid=%b busy=%b, required 0 1", tw_valid, busy);
    end
    @(negedge clk);
    for (int w = 0; w < 80; w++) begin
      k = m_k(w);
      tests_run++;
      if (tw_valid !== 1'b1 || tw_k !== 4'(k) || tw_stage !== 3'(w / 16) || tw_re !== m_re(k) ||
          tw_im !== m_im(k, inv) || tw_last !== (w == 79) || done !== 1'b0 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream inv=%0d word %0d: valid=%b k=%0d s=%0d re=%h im=%h last=%b done=%b busy=%b, required k=%0d s=%0d re=%h im=%h last=%b",
                 inv, w, tw_valid, tw_k, tw_stage, tw_re, tw_im, tw_last, done, busy,
                 k, w / 16, m_re(k), m_im(k, inv), (w == 79));
      end
      if (w == 68 || w == 72 || w == 76) begin
        logic [15:0] xre;
        logic [15:0] xim;
        if (w == 68)      begin xre = 16'h00B5; xim = inv ? 16'h00B5 : 16'hFF4B; end
        else if (w == 72) begin xre = 16'h0000; xim = inv ? 16'h0100 : 16'hFF00; end
        else              begin xre = 16'hFF4B; xim = inv ? 16'h00B5 : 16'hFF4B; end
        tests_run++;
        if (tw_re !== xre || tw_im !== xim) begin
          tests_failed++;
          $display("FAIL stage4_spot inv=%0d word %0d: re=%h im=%h, required re=%h im=%h", inv, w, tw_re, tw_im, xre, xim);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || tw_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_pulse: done=%b busy=%b valid=%b, required 1 0 0", done, busy, tw_valid);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_width: done=%b, required 0", done);
    end
  endtask

  task automatic test_backpressure;
    int          w;
    int          k;
    bit          seen_done;
    bit          pv;
    bit          pr;
    logic [15:0] pre;
    logic [15:0] pim;
    logic [3:0]  pk;
    logic [2:0]  ps;
    logic        pl;
    w = 0; seen_done = 1'b0; pv = 1'b0; pr = 1'b1;
    pre = '0; pim = '0; pk = '0; ps = '0; pl = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    inverse  = 1'b0;
    tw_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 2000 && !seen_done; cyc++) begin
      if (pv && !pr) begin
        tests_run++;
        if (tw_valid !== 1'b1 || tw_re !== pre || tw_im !== pim || tw_k !== pk || tw_stage !== ps || tw_last !== pl) begin
          tests_failed++;
          $display("FAIL stall_hold cyc %0d: valid=%b re=%h im=%h k=%0d s=%0d last=%b, required 1 %h %h %0d %0d %b",
                   cyc, tw_valid, tw_re, tw_im, tw_k, tw_stage, tw_last, pre, pim, pk, ps, pl);
        end
      end
      if (done === 1'b1) begin
        seen_done = 1'b1;
        tests_run++;
        if (w != 80) begin
          tests_failed++;
          $display("FAIL bp_word_count: got %0d words, required 80", w);
        end
      end else begin
        tw_ready = 1'($urandom_range(0, 1));
        start    = (w == 20);
        if (tw_valid === 1'b1 && tw_ready) begin
          k = m_k(w);
          tests_run++;
          if (w >= 80 || tw_k !== 4'(k) || tw_stage !== 3'(w / 16) || tw_re !== m_re(k) ||
              tw_im !== m_im(k, 1'b0) || tw_last !== (w == 79)) begin
            tests_failed++;
            $display("FAIL bp_word %0d: k=%0d s=%0d re=%h im=%h last=%b, required k=%0d s=%0d re=%h im=%h last=%b",
                     w, tw_k, tw_stage, tw_re, tw_im, tw_last, k, w / 16, m_re(k), m_im(k, 1'b0), (w == 79));
          end
          w++;
        end
        pv = tw_valid; pr = tw_ready;
        pre = tw_re; pim = tw_im; pk = tw_k; ps = tw_stage; pl = tw_last;
        @(negedge clk);
      end
    end
    start    = 1'b0;
    tw_ready = 1'b1;
    if (!seen_done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL bp_timeout: done not seen, words=%0d, required 80", w);
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || tw_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrun_start_ignored: busy=%b valid=%b, required 0 0", busy, tw_valid);
    end
  endtask

  task automatic test_abort;
    int k;
    @(negedge clk);
    start    = 1'b1;
    inverse  = 1'b0;
    tw_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    repeat (30) @(negedge clk);
    tests_run++;
    if (tw_valid !== 1'b1 || tw_stage !== 3'd1 || tw_k !== 4'd0) begin
      tests_failed++;
      $display("FAIL word30: valid=%b s=%0d k=%0d, required 1 1 0", tw_valid, tw_stage, tw_k);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || tw_valid !== 1'b0 || tw_last !== 1'b0 ||
        tw_re !== 16'h0 || tw_im !== 16'h0 || tw_k !== 4'h0 || tw_stage !== 3'h0) begin
      tests_failed++;
      $display("FAIL async_abort: busy=%b done=%b valid=%b last=%b re=%h im=%h k=%0d s=%0d, required all 0",
               busy, done, tw_valid, tw_last, tw_re, tw_im, tw_k, tw_stage);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL no_done_after_abort cyc %0d: done=%b busy=%b, required 0 0", i, done, busy);
      end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      k = m_k(w);
      tests_run++;
      if (tw_valid !== 1'b1 || tw_k !== 4'(k) || tw_stage !== 3'd0 || tw_re !== m_re(k) || tw_im !== m_im(k, 1'b0)) begin
        tests_failed++;
        $display("FAIL restart word %0d: valid=%b k=%0d s=%0d re=%h im=%h, required 1 %0d 0 %h %h",
                 w, tw_valid, tw_k, tw_stage, tw_re, tw_im, k, m_re(k), m_im(k, 1'b0));
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    inverse  = 1'b0;
    tw_ready = 1'b0;
    test_reset();
    test_stream(1'b0);
    test_stream(1'b1);
    test_backpressure();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
